// File: rtl/mips_defs.sv
// -----------------------------------------------------------------------------
// mips_defs
// Shared definitions for the MIPS pipeline: ALU operation codes carried on
// ealuc (also used by the ID-stage decoder) and the state encoding of the
// iterative multiplier in the EXE stage.
// -----------------------------------------------------------------------------
package mips_defs;

    localparam logic [3:0] ALUC_ADD = 4'b0000;
    localparam logic [3:0] ALUC_AND = 4'b0001;
    localparam logic [3:0] ALUC_XOR = 4'b0010;
    localparam logic [3:0] ALUC_SLL = 4'b0011;
    localparam logic [3:0] ALUC_SUB = 4'b0100;
    localparam logic [3:0] ALUC_OR  = 4'b0101;
    localparam logic [3:0] ALUC_LUI = 4'b0110;
    localparam logic [3:0] ALUC_SRL = 4'b0111;
    localparam logic [3:0] ALUC_MUL = 4'b1000;
    localparam logic [3:0] ALUC_SRA = 4'b1111;

    // Width of the multiplier step counter (32 steps for a 32-bit operand).
    localparam int MUL_CNT_W = 5;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_BUSY = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/exe_mul.sv
// -----------------------------------------------------------------------------
// exe_mul
// Iterative shift-add multiplier, one partial product per clock.
// IDLE latches the operands when start is high, BUSY performs 32 steps,
// DONE presents the low XLEN bits of the product for one cycle.
// Ports:
//   clk, clrn     clock, asynchronous active-low reset
//   start         request a multiply (sampled only in IDLE)
//   a, b          multiplicand / multiplier
//   busy          high in BUSY
//   done          high in DONE (product valid)
//   product       accumulator contents
// -----------------------------------------------------------------------------
module exe_mul
    import mips_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] product
);

    mul_state_t              r_state;
    mul_state_t              w_next_state;
    logic [MUL_CNT_W-1:0]    r_count;
    logic [XLEN-1:0]         r_mcand;
    logic [XLEN-1:0]         r_mplier;
    logic [XLEN-1:0]         r_acc;

    // State register.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_state <= MUL_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: the BUSY edge that completes step 31 moves to DONE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            MUL_IDLE: begin
                if (start) begin
                    w_next_state = MUL_BUSY;
                end else begin
                    w_next_state = MUL_IDLE;
                end
            end
            MUL_BUSY: begin
                if (r_count == 5'd31) begin
                    w_next_state = MUL_DONE;
                end else begin
                    w_next_state = MUL_BUSY;
                end
            end
            MUL_DONE: w_next_state = MUL_IDLE;
            default:  w_next_state = MUL_IDLE;
        endcase
    end

    // Operand latch and shift-add datapath. Operands are captured only on
    // the start edge, so inputs held upstream during BUSY have no effect.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            r_count  <= {MUL_CNT_W{1'b0}};
            r_mcand  <= {XLEN{1'b0}};
            r_mplier <= {XLEN{1'b0}};
            r_acc    <= {XLEN{1'b0}};
        end else begin
            case (r_state)
                MUL_IDLE: begin
                    if (start) begin
                        r_mcand  <= a;
                        r_mplier <= b;
                        r_acc    <= {XLEN{1'b0}};
                        r_count  <= {MUL_CNT_W{1'b0}};
                    end
                end
                MUL_BUSY: begin
                    if (r_mplier[0]) begin
                        r_acc <= r_acc + r_mcand;
                    end
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_count  <= r_count + 5'd1;
                end
                default: begin
                    r_count <= r_count;
                end
            endcase
        end
    end

    assign busy    = (r_state == MUL_BUSY);
    assign done    = (r_state == MUL_DONE);
    assign product = r_acc;

endmodule

// File: rtl/exe_stage.sv
// -----------------------------------------------------------------------------
// exe_stage
// EXE stage of the five-stage MIPS pipeline: B-operand mux, ALU, iterative
// multiplier, stall generation and the EXE/MEM pipeline register.
// Ports:
//   clk, clrn                     clock, asynchronous active-low reset
//   ewreg, em2reg, ewmem          controls from ID/EXE
//   ealuc, ealuimm, edestReg      ALU op, immediate select, destination
//   eqa, eqb, eimm32              operands and immediate
//   stall                         combinational hold request to PC/IF/ID/ID-EXE
//   mwreg, mm2reg, mwmem,
//   mdestReg, mr, mqb             registered EXE/MEM outputs
// -----------------------------------------------------------------------------
module exe_stage
    import mips_defs::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            clrn,
    input  logic            ewreg,
    input  logic            em2reg,
    input  logic            ewmem,
    input  logic [3:0]      ealuc,
    input  logic            ealuimm,
    input  logic [4:0]      edestReg,
    input  logic [XLEN-1:0] eqa,
    input  logic [XLEN-1:0] eqb,
    input  logic [XLEN-1:0] eimm32,
    output logic            stall,
    output logic            mwreg,
    output logic            mm2reg,
    output logic            mwmem,
    output logic [4:0]      mdestReg,
    output logic [XLEN-1:0] mr,
    output logic [XLEN-1:0] mqb
);

    logic [XLEN-1:0] w_b;
    logic [XLEN-1:0] w_alu;
    logic [XLEN-1:0] w_result;
    logic [XLEN-1:0] w_product;
    logic            w_is_mul;
    logic            w_mul_busy;
    logic            w_mul_done;

    assign w_b      = ealuimm ? eimm32 : eqb;
    assign w_is_mul = (ealuc == ALUC_MUL);

    exe_mul #(.XLEN(XLEN)) u_mul (
        .clk     (clk),
        .clrn    (clrn),
        .start   (w_is_mul),
        .a       (eqa),
        .b       (w_b),
        .busy    (w_mul_busy),
        .done    (w_mul_done),
        .product (w_product)
    );

    // Combinational ALU; MUL and unused codes give 0 here (MUL result comes
    // from the multiplier in its DONE cycle).
    always_comb begin
        w_alu = {XLEN{1'b0}};
        case (ealuc)
            ALUC_ADD: w_alu = eqa + w_b;
            ALUC_SUB: w_alu = eqa - w_b;
            ALUC_AND: w_alu = eqa & w_b;
            ALUC_OR:  w_alu = eqa | w_b;
            ALUC_XOR: w_alu = eqa ^ w_b;
            ALUC_LUI: w_alu = w_b << 16;
            ALUC_SLL: w_alu = w_b << eqa[4:0];
            ALUC_SRL: w_alu = w_b >> eqa[4:0];
            ALUC_SRA: w_alu = XLEN'($signed(w_b) >>> eqa[4:0]);
            default:  w_alu = {XLEN{1'b0}};
        endcase
    end

    // Stall while a MUL waits to start in IDLE and throughout BUSY; it
    // depends only on multiplier state and ealuc, never on the m* outputs.
    always_comb begin
        stall = 1'b0;
        if (w_mul_busy) begin
            stall = 1'b1;
        end else if (w_is_mul && !w_mul_done) begin
            stall = 1'b1;
        end else begin
            stall = 1'b0;
        end
    end

    // Result select: product in the multiplier's DONE cycle, ALU otherwise.
    always_comb begin
        w_result = w_alu;
        if (w_mul_done) begin
            w_result = w_product;
        end else begin
            w_result = w_alu;
        end
    end

    // EXE/MEM register; a stalled cycle sends an all-zero bubble to MEM.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            mwreg    <= 1'b0;
            mm2reg   <= 1'b0;
            mwmem    <= 1'b0;
            mdestReg <= 5'd0;
            mr       <= {XLEN{1'b0}};
            mqb      <= {XLEN{1'b0}};
        end else if (stall) begin
            mwreg    <= 1'b0;
            mm2reg   <= 1'b0;
            mwmem    <= 1'b0;
            mdestReg <= 5'd0;
            mr       <= {XLEN{1'b0}};
            mqb      <= {XLEN{1'b0}};
        end else begin
            mwreg    <= ewreg;
            mm2reg   <= em2reg;
            mwmem    <= ewmem;
            mdestReg <= edestReg;
            mr       <= w_result;
            mqb      <= eqb;
        end
    end

endmodule

// File: tb/tb_exe_stage.sv
// -----------------------------------------------------------------------------
// tb_exe_stage
// Scoreboard bench for exe_stage. The driver issues instructions, holding
// them for as many cycles as the reference model says the stage needs, and
// pushes the expected stall value and EXE/MEM contents per cycle into queues.
// A monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_exe_stage;

    localparam int XLEN = 32;

    logic            clk;
    logic            clrn;
    logic            ewreg, em2reg, ewmem;
    logic [3:0]      ealuc;
    logic            ealuimm;
    logic [4:0]      edestReg;
    logic [XLEN-1:0] eqa, eqb, eimm32;
    logic            stall;
    logic            mwreg, mm2reg, mwmem;
    logic [4:0]      mdestReg;
    logic [XLEN-1:0] mr, mqb;

    int checks = 0;
    int errors = 0;

    // Expected EXE/MEM contents: {wreg, m2reg, wmem, dest, r, qb}
    logic [71:0] m_q[$];
    logic        stall_q[$];

    exe_stage #(.XLEN(XLEN)) dut (
        .clk      (clk),
        .clrn     (clrn),
        .ewreg    (ewreg),
        .em2reg   (em2reg),
        .ewmem    (ewmem),
        .ealuc    (ealuc),
        .ealuimm  (ealuimm),
        .edestReg (edestReg),
        .eqa      (eqa),
        .eqb      (eqb),
        .eimm32   (eimm32),
        .stall    (stall),
        .mwreg    (mwreg),
        .mm2reg   (mm2reg),
        .mwmem    (mwmem),
        .mdestReg (mdestReg),
        .mr       (mr),
        .mqb      (mqb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [71:0] m_now();
        return {mwreg, mm2reg, mwmem, mdestReg, mr, mqb};
    endfunction

    // Reference result of one instruction, straight from the opcode table.
    function automatic logic [31:0] ref_result(input logic [3:0] op,
                                               input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] full;
        case (op)
            4'b0000: return a + b;
            4'b0100: return a - b;
            4'b0001: return a & b;
            4'b0101: return a | b;
            4'b0010: return a ^ b;
            4'b0110: return {b[15:0], 16'h0000};
            4'b0011: return b << a[4:0];
            4'b0111: return b >> a[4:0];
            4'b1111: return 32'($signed(b) >>> a[4:0]);
            4'b1000: begin
                full = 64'(a) * 64'(b);
                return full[31:0];
            end
            default: return 32'h0000_0000;
        endcase
    endfunction

    // Issue one instruction (called at posedge+2); held for 34 cycles if MUL.
    task automatic issue(input logic [3:0] op, input logic wr, input logic m2r,
                         input logic wm, input logic isel, input logic [4:0] dst,
                         input logic [31:0] qa, input logic [31:0] qb,
                         input logic [31:0] imm);
        int          n;
        logic [31:0] b;
        logic [71:0] exp;
        b  = isel ? imm : qb;
        n  = (op == 4'b1000) ? 34 : 1;
        ewreg = wr; em2reg = m2r; ewmem = wm; ealuc = op; ealuimm = isel;
        edestReg = dst; eqa = qa; eqb = qb; eimm32 = imm;
        for (int k = 0; k < n; k++) begin
            stall_q.push_back(k != n - 1);
            if (k == n - 1) begin
                exp = {wr, m2r, wm, dst, ref_result(op, qa, b), qb};
            end else begin
                exp = 72'h0;
            end
            @(posedge clk);
            m_q.push_back(exp);
            #2;
        end
    endtask

    // Monitor: compare stall for the coming edge and m* from the last edge.
    always @(negedge clk) begin
        if (stall_q.size() > 0) begin
            chk("stall", {71'h0, stall}, {71'h0, stall_q.pop_front()});
        end
        if (m_q.size() > 0) begin
            chk("m_out", m_now(), m_q.pop_front());
        end
    end

    initial begin
        logic [3:0] op;
        clrn = 1'b0;
        ewreg = 1'b0; em2reg = 1'b0; ewmem = 1'b0; ealuc = 4'b0000; ealuimm = 1'b0;
        edestReg = 5'd0; eqa = 32'h0; eqb = 32'h0; eimm32 = 32'h0;

        // Reset held across clock edges.
        repeat (3) @(posedge clk);
        #2;
        chk("rst_hold_m", m_now(), 72'h0);
        chk("rst_hold_stall", {71'h0, stall}, 72'h0);
        clrn = 1'b1;

        // Directed ALU sweep.
        issue(4'b0000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd1, 32'hFFFF_FFFF, 32'h1, 32'h0);
        issue(4'b0100, 1'b1, 1'b1, 1'b0, 1'b0, 5'd2, 32'h3, 32'h5, 32'h0);
        issue(4'b1111, 1'b1, 1'b0, 1'b1, 1'b0, 5'd3, 32'h4, 32'h8000_0000, 32'h0);
        issue(4'b0110, 1'b1, 1'b0, 1'b0, 1'b1, 5'd4, 32'h0, 32'h0, 32'h1234);
        // Immediate select: mr=15, mqb=99.
        issue(4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 32'd10, 32'd99, 32'd5);
        // MUL 7x6 then back-to-back MULs.
        issue(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd8, 32'd7, 32'd6, 32'h0);
        issue(4'b1000, 1'b1, 1'b0, 1'b0, 1'b0, 5'd9, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0);
        issue(4'b1000, 1'b1, 1'b0, 1'b0, 1'b1, 5'd10, 32'd3, 32'd77, 32'd3);

        // Asynchronous reset between edges clears m* immediately.
        issue(4'b0101, 1'b1, 1'b1, 1'b1, 1'b0, 5'd11, 32'hA5A5_0000, 32'h0000_5A5A, 32'h0);
        #4;
        clrn = 1'b0;
        #1;
        chk("async_rst_m", m_now(), 72'h0);
        chk("async_rst_stall", {71'h0, stall}, 72'h0);
        @(posedge clk);
        #2;
        clrn = 1'b1;

        // Abort a MUL at BUSY count=10 by reset.
        ewreg = 1'b1; em2reg = 1'b0; ewmem = 1'b0; ealuc = 4'b1000; ealuimm = 1'b0;
        edestReg = 5'd12; eqa = 32'h0001_2345; eqb = 32'h0000_0100; eimm32 = 32'h0;
        repeat (11) begin
            @(posedge clk);
            #1;
            chk("abort_busy_stall", {71'h0, stall}, {71'h0, 1'b1});
            chk("abort_busy_m", m_now(), 72'h0);
        end
        #1;
        clrn = 1'b0;
        #1;
        chk("abort_rst_m", m_now(), 72'h0);
        ealuc = 4'b0000;
        #1;
        chk("abort_rst_stall", {71'h0, stall}, 72'h0);
        @(posedge clk);
        #2;
        clrn = 1'b1;
        // Following instructions must see no trace of the aborted product.
        issue(4'b1001, 1'b1, 1'b0, 1'b0, 1'b0, 5'd13, 32'h0001_2345, 32'h0000_0100, 32'h0);
        issue(4'b1100, 1'b0, 1'b0, 1'b1, 1'b0, 5'd14, 32'h1, 32'h2, 32'h0);
        issue(4'b0011, 1'b1, 1'b0, 1'b0, 1'b0, 5'd15, 32'd31, 32'h0000_0003, 32'h0);

        // Randomised instruction stream.
        for (int i = 0; i < 200; i++) begin
            op = 4'($urandom_range(0, 15));
            issue(op, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  5'($urandom), $urandom, $urandom, $urandom);
        end

        // Bounded drain of the scoreboard.
        for (int k = 0; k < 10; k++) begin
            if (m_q.size() > 0 || stall_q.size() > 0) begin
                @(negedge clk);
                #1;
            end
        end
        if (m_q.size() > 0 || stall_q.size() > 0) begin
            errors++;
            $display("FAIL drain pending %0d expected 0", m_q.size() + stall_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
